step_dir_monitor: RTL and testbench

Receive-side decoder for the step/dir motor interface. It samples an asynchronous step/dir pair (from an external controller or looped back from the local step generator), keeps a signed absolute position, and measures the step period. It also checks pulse-width and direction-setup timing and flags violations. It sits beside the step generator in the motor-control CPLD and provides position feedback and protocol checking.

---
 rtl/step_dir_monitor.sv | 148 ++++++++++++++
 tb/tb_step_dir_monitor.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/step_dir_monitor.sv
// Receive-side step/dir decoder: synchronizes the step/dir pair, tracks signed
// position, measures step period and flags direction-setup / pulse-width violations.
module step_dir_monitor #(
  parameter int DIR_SETUP    = 255,
  parameter int MIN_HIGH     = 2,
  parameter int IDLE_TIMEOUT = 50000
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        step_in,
  input  logic        dir_in,
  input  logic        pos_load,
  input  logic [18:0] pos_value,
  input  logic        clr_err,
  output logic [18:0] position,
  output logic [15:0] period,
  output logic        period_valid,
  output logic        moving,
  output logic        dir_err,
  output logic        width_err
);

  localparam logic [7:0]  DIR_SETUP_C = 8'(DIR_SETUP);
  localparam logic [7:0]  MIN_HIGH_C  = 8'(MIN_HIGH);
  localparam logic [15:0] IDLE_C      = 16'(IDLE_TIMEOUT);

  typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

  state_t      state_q, state_d;
  logic        step_s1_q, step_s1_d, step_s2_q, step_s2_d, step_dly_q, step_dly_d;
  logic        dir_s1_q, dir_s1_d, dir_s2_q, dir_s2_d, dir_dly_q, dir_dly_d;
  logic [18:0] position_q, position_d;
  logic [15:0] period_q, period_d;
  logic        period_valid_q, period_valid_d;
  logic [15:0] per_cnt_q, per_cnt_d;
  logic [15:0] idle_cnt_q, idle_cnt_d;
  logic [7:0]  dir_cnt_q, dir_cnt_d;
  logic [7:0]  high_cnt_q, high_cnt_d;
  logic        dir_err_q, dir_err_d;
  logic        width_err_q, width_err_d;

  logic        rise, fall, dir_chg, dir_set, width_set;
  logic [7:0]  setup_cnt;

  always_comb begin
    step_s1_d      = step_in;
    step_s2_d      = step_s1_q;
    step_dly_d     = step_s2_q;
    dir_s1_d       = dir_in;
    dir_s2_d       = dir_s1_q;
    dir_dly_d      = dir_s2_q;
    state_d        = state_q;
    position_d     = position_q;
    period_d       = period_q;
    period_valid_d = 1'b0;
    idle_cnt_d     = idle_cnt_q;

    rise    = step_s2_q & ~step_dly_q;
    fall    = ~step_s2_q & step_dly_q;
    dir_chg = dir_s2_q ^ dir_dly_q;

    per_cnt_d = rise ? 16'd1 : ((per_cnt_q == 16'hFFFF) ? per_cnt_q : per_cnt_q + 16'd1);

    dir_cnt_d = dir_chg ? 8'd0 : ((dir_cnt_q == 8'hFF) ? dir_cnt_q : dir_cnt_q + 8'd1);
    // A dir change landing on the same cycle as the rise counts as zero setup time.
    setup_cnt = dir_chg ? 8'd0 : dir_cnt_q;
    dir_set   = rise && (setup_cnt < DIR_SETUP_C);

    if (rise)
      high_cnt_d = 8'd1;
    else if (step_s2_q && high_cnt_q != 8'hFF)
      high_cnt_d = high_cnt_q + 8'd1;
    else
      high_cnt_d = high_cnt_q;
    width_set = fall && (high_cnt_q < MIN_HIGH_C);

    if (pos_load)
      position_d = pos_value;
    else if (rise)
      position_d = dir_s2_q ? position_q + 19'd1 : position_q - 19'd1;

    dir_err_d   = dir_set   ? 1'b1 : (clr_err ? 1'b0 : dir_err_q);
    width_err_d = width_set ? 1'b1 : (clr_err ? 1'b0 : width_err_q);

    case (state_q)
      IDLE: begin
        idle_cnt_d = 16'd0;
        if (rise) state_d = ACTIVE;
      end
      default: begin
        if (rise) begin
          idle_cnt_d     = 16'd0;
          period_d       = per_cnt_q;
          period_valid_d = 1'b1;
        end else begin
          idle_cnt_d = idle_cnt_q + 16'd1;
          if (idle_cnt_d == IDLE_C) state_d = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      step_s1_q      <= 1'b0;
      step_s2_q      <= 1'b0;
      step_dly_q     <= 1'b0;
      dir_s1_q       <= 1'b0;
      dir_s2_q       <= 1'b0;
      dir_dly_q      <= 1'b0;
      position_q     <= 19'd0;
      period_q       <= 16'd0;
      period_valid_q <= 1'b0;
      per_cnt_q      <= 16'd0;
      idle_cnt_q     <= 16'd0;
      dir_cnt_q      <= 8'hFF;
      high_cnt_q     <= 8'd0;
      dir_err_q      <= 1'b0;
      width_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      step_s1_q      <= step_s1_d;
      step_s2_q      <= step_s2_d;
      step_dly_q     <= step_dly_d;
      dir_s1_q       <= dir_s1_d;
      dir_s2_q       <= dir_s2_d;
      dir_dly_q      <= dir_dly_d;
      position_q     <= position_d;
      period_q       <= period_d;
      period_valid_q <= period_valid_d;
      per_cnt_q      <= per_cnt_d;
      idle_cnt_q     <= idle_cnt_d;
      dir_cnt_q      <= dir_cnt_d;
      high_cnt_q     <= high_cnt_d;
      dir_err_q      <= dir_err_d;
      width_err_q    <= width_err_d;
    end
  end

  assign position     = position_q;
  assign period       = period_q;
  assign period_valid = period_valid_q;
  assign moving       = (state_q == ACTIVE);
  assign dir_err      = dir_err_q;
  assign width_err    = width_err_q;

endmodule

// File: tb/tb_step_dir_monitor.sv
// Directed plus randomized bench for step_dir_monitor; a step-level model tracks
// expected position, period and strobe counts.
module tb_step_dir_monitor;

  logic        CLK = 1'b0;
  logic        reset, step_in, dir_in, pos_load, clr_err;
  logic [18:0] pos_value;
  logic [18:0] position;
  logic [15:0] period;
  logic        period_valid, moving, dir_err, width_err;

  int          checks = 0;
  int          failures = 0;
  int          pv_cnt = 0;
  int          pv0, cnt, n, h, l, prev_int, nd;
  logic [18:0] exp_pos;
  logic [15:0] exp_period;

  step_dir_monitor #(.DIR_SETUP(255), .MIN_HIGH(2), .IDLE_TIMEOUT(100)) dut (
    .CLK(CLK), .reset(reset), .step_in(step_in), .dir_in(dir_in),
    .pos_load(pos_load), .pos_value(pos_value), .clr_err(clr_err),
    .position(position), .period(period), .period_valid(period_valid),
    .moving(moving), .dir_err(dir_err), .width_err(width_err)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (period_valid === 1'b1) pv_cnt++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on a negedge; high for h sampling edges, low for l, so rise-to-rise is h+l.
  task automatic pulse(input int hi, input int lo);
    step_in = 1'b1;
    exp_pos = dir_in ? exp_pos + 19'd1 : exp_pos - 19'd1;
    repeat (hi) @(negedge CLK);
    step_in = 1'b0;
    repeat (lo) @(negedge CLK);
  endtask

  task automatic set_dir(input logic v);
    dir_in = v;
    repeat (300) @(negedge CLK);
  endtask

  task automatic load(input logic [18:0] v);
    pos_load = 1'b1;
    pos_value = v;
    @(negedge CLK);
    pos_load = 1'b0;
    exp_pos = v;
  endtask

  task automatic clear_errs;
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
  endtask

  initial begin
    reset = 1'b0; step_in = 1'b0; dir_in = 1'b1; pos_load = 1'b0;
    clr_err = 1'b0; pos_value = 19'd0; exp_pos = 19'd0; exp_period = 16'd0;
    repeat (3) @(negedge CLK);
    check("rst_position", 32'(position), 32'd0);
    check("rst_period", 32'(period), 32'd0);
    check("rst_pvalid", 32'(period_valid), 32'd0);
    check("rst_moving", 32'(moving), 32'd0);
    check("rst_dir_err", 32'(dir_err), 32'd0);
    check("rst_width_err", 32'(width_err), 32'd0);
    reset = 1'b1;
    repeat (300) @(negedge CLK);

    // Ten forward steps, 10-cycle period
    pv0 = pv_cnt;
    for (int i = 0; i < 10; i++) pulse(4, 6);
    repeat (4) @(negedge CLK);
    check("fwd_position", 32'(position), 32'(exp_pos));
    check("fwd_position_abs", 32'(position), 32'd10);
    check("fwd_period", 32'(period), 32'd10);
    check("fwd_pv_count", 32'(pv_cnt - pv0), 32'd9);
    check("fwd_moving", 32'(moving), 32'd1);
    check("fwd_dir_err", 32'(dir_err), 32'd0);
    check("fwd_width_err", 32'(width_err), 32'd0);

    // Reverse from zero, then wrap +1 at the positive limit
    load(19'd0);
    set_dir(1'b0);
    for (int i = 0; i < 3; i++) pulse(4, 6);
    repeat (4) @(negedge CLK);
    check("rev_position", 32'(position), 32'h7FFFD);
    load(19'h3FFFF);
    set_dir(1'b1);
    pulse(4, 6);
    repeat (4) @(negedge CLK);
    check("wrap_position", 32'(position), 32'h40000);
    check("wrap_dir_err", 32'(dir_err), 32'd0);

    // Direction setup violation; step counted in new direction
    dir_in = 1'b0;
    repeat (100) @(negedge CLK);
    pulse(4, 6);
    repeat (4) @(negedge CLK);
    check("setup_dir_err", 32'(dir_err), 32'd1);
    check("setup_position", 32'(position), 32'(exp_pos));
    check("setup_position_abs", 32'(position), 32'h3FFFF);
    clear_errs();
    @(negedge CLK);
    check("setup_clr", 32'(dir_err), 32'd0);
    dir_in = 1'b1;
    repeat (100) @(negedge CLK);
    step_in = 1'b1;
    exp_pos = exp_pos + 19'd1;
    @(negedge CLK);
    @(negedge CLK);
    clr_err = 1'b1;
    @(negedge CLK);
    clr_err = 1'b0;
    @(negedge CLK);
    step_in = 1'b0;
    repeat (6) @(negedge CLK);
    check("setup_clr_coincident", 32'(dir_err), 32'd1);
    check("setup2_position", 32'(position), 32'(exp_pos));
    clear_errs();
    repeat (300) @(negedge CLK);
    check("setup_final_clr", 32'(dir_err), 32'd0);

    // Pulse width
    pulse(1, 6);
    repeat (4) @(negedge CLK);
    check("width_short_err", 32'(width_err), 32'd1);
    check("width_short_pos", 32'(position), 32'(exp_pos));
    clear_errs();
    pulse(2, 6);
    repeat (4) @(negedge CLK);
    check("width_ok_err", 32'(width_err), 32'd0);
    check("width_ok_dir_err", 32'(dir_err), 32'd0);

    // Idle timeout: moving falls 100 cycles after the rise edge
    step_in = 1'b1;
    exp_pos = exp_pos + 19'd1;
    cnt = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge CLK);
      cnt++;
      if (cnt == 4) step_in = 1'b0;
      if (cnt > 3 && moving == 1'b0) break;
    end
    check("idle_fall_cycle", 32'(cnt), 32'd103);
    pv0 = pv_cnt;
    pulse(4, 6);
    repeat (4) @(negedge CLK);
    check("idle_first_rise_pv", 32'(pv_cnt - pv0), 32'd0);
    check("idle_first_rise_moving", 32'(moving), 32'd1);

    // Load coincident with a rise wins
    step_in = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    pos_load = 1'b1;
    pos_value = 19'h12345;
    @(negedge CLK);
    pos_load = 1'b0;
    @(negedge CLK);
    step_in = 1'b0;
    exp_pos = 19'h12345;
    repeat (6) @(negedge CLK);
    check("load_vs_rise", 32'(position), 32'h12345);

    // Randomized bursts
    for (int b = 0; b < 12; b++) begin
      nd = int'($urandom_range(0, 1));
      if (nd != int'(dir_in)) set_dir(nd[0]);
      else repeat (150) @(negedge CLK);
      n = int'($urandom_range(1, 6));
      pv0 = pv_cnt;
      prev_int = 0;
      for (int i = 0; i < n; i++) begin
        h = int'($urandom_range(2, 8));
        l = int'($urandom_range(3, 8));
        if (i > 0) exp_period = 16'(prev_int);
        pulse(h, l);
        prev_int = h + l;
      end
      repeat (4) @(negedge CLK);
      check("rand_position", 32'(position), 32'(exp_pos));
      check("rand_pv_count", 32'(pv_cnt - pv0), 32'(n - 1));
      if (n >= 2) check("rand_period", 32'(period), 32'(exp_period));
      check("rand_errs", {30'd0, dir_err, width_err}, 32'd0);
    end

    // Reset mid-pulse
    step_in = 1'b1;
    repeat (3) @(negedge CLK);
    reset = 1'b0;
    #1;
    check("midrst_position", 32'(position), 32'd0);
    check("midrst_moving", 32'(moving), 32'd0);
    check("midrst_period", 32'(period), 32'd0);
    step_in = 1'b0;
    @(negedge CLK);
    reset = 1'b1;
    repeat (10) @(negedge CLK);
    check("postrst_position", 32'(position), 32'd0);
    check("postrst_flags", {28'd0, period_valid, moving, dir_err, width_err}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
